// File: rtl/id_ex_elastic_stage.sv
// Elastic pipeline stage: valid/ready payload+control register with optional one-entry skid,
// global BUSYWAIT freeze, FLUSH-to-bubble and a saturating stall counter.
module id_ex_elastic_stage #(
    parameter int unsigned          DATA_W      = 133,
    parameter int unsigned          CTRL_W      = 22,
    parameter logic [CTRL_W-1:0]    CTRL_BUBBLE = '0,
    parameter bit                   SKID_EN     = 1'b1
) (
    input  logic                CLK,
    input  logic                RESET,
    input  logic                BUSYWAIT,
    input  logic                FLUSH,
    input  logic                IN_VALID,
    output logic                IN_READY,
    input  logic [DATA_W-1:0]   IN_DATA,
    input  logic [CTRL_W-1:0]   IN_CTRL,
    output logic                OUT_VALID,
    input  logic                OUT_READY,
    output logic [DATA_W-1:0]   OUT_DATA,
    output logic [CTRL_W-1:0]   OUT_CTRL,
    output logic [15:0]         STALL_COUNT
);

    typedef enum logic [1:0] {
        ST_EMPTY = 2'd0,
        ST_FULL  = 2'd1,
        ST_SKID  = 2'd2
    } state_t;

    state_t              state_reg, state_next;
    logic [DATA_W-1:0]   main_data_reg, main_data_next;
    logic [CTRL_W-1:0]   main_ctrl_reg, main_ctrl_next;
    logic [DATA_W-1:0]   skid_data_reg, skid_data_next;
    logic [CTRL_W-1:0]   skid_ctrl_reg, skid_ctrl_next;
    logic [15:0]         stall_count_reg, stall_count_next;

    logic out_valid;
    logic in_ready;
    logic accept;
    logic release_ok;

    assign out_valid = (state_reg != ST_EMPTY);

    // With the skid slot, readiness depends only on our own state, never on OUT_READY.
    generate
        if (SKID_EN) begin : g_skid_ready
            assign in_ready = (state_reg != ST_SKID) && !BUSYWAIT;
        end else begin : g_pass_ready
            assign in_ready = !BUSYWAIT && ((state_reg == ST_EMPTY) || OUT_READY);
        end
    endgenerate

    assign accept     = IN_VALID && in_ready;
    assign release_ok = out_valid && OUT_READY && !BUSYWAIT;

    always_comb begin
        state_next       = state_reg;
        main_data_next   = main_data_reg;
        main_ctrl_next   = main_ctrl_reg;
        skid_data_next   = skid_data_reg;
        skid_ctrl_next   = skid_ctrl_reg;
        stall_count_next = stall_count_reg;

        if ((BUSYWAIT || (out_valid && !OUT_READY)) && (stall_count_reg != 16'hFFFF)) begin
            stall_count_next = stall_count_reg + 16'd1;
        end

        if (FLUSH) begin
            state_next = ST_EMPTY;
        end else if (!BUSYWAIT) begin
            case (state_reg)
                ST_EMPTY: begin
                    if (accept) begin
                        main_data_next = IN_DATA;
                        main_ctrl_next = IN_CTRL;
                        state_next     = ST_FULL;
                    end
                end
                ST_FULL: begin
                    if (release_ok && accept) begin
                        main_data_next = IN_DATA;
                        main_ctrl_next = IN_CTRL;
                    end else if (release_ok) begin
                        state_next = ST_EMPTY;
                    end else if (accept) begin
                        skid_data_next = IN_DATA;
                        skid_ctrl_next = IN_CTRL;
                        state_next     = ST_SKID;
                    end
                end
                ST_SKID: begin
                    if (release_ok) begin
                        main_data_next = skid_data_reg;
                        main_ctrl_next = skid_ctrl_reg;
                        state_next     = ST_FULL;
                    end
                end
                default: state_next = ST_EMPTY;
            endcase
        end
    end

    always_ff @(posedge CLK) begin
        if (RESET) begin
            state_reg       <= ST_EMPTY;
            main_data_reg   <= '0;
            main_ctrl_reg   <= '0;
            skid_data_reg   <= '0;
            skid_ctrl_reg   <= '0;
            stall_count_reg <= '0;
        end else begin
            state_reg       <= state_next;
            main_data_reg   <= main_data_next;
            main_ctrl_reg   <= main_ctrl_next;
            skid_data_reg   <= skid_data_next;
            skid_ctrl_reg   <= skid_ctrl_next;
            stall_count_reg <= stall_count_next;
        end
    end

    assign IN_READY    = in_ready;
    assign OUT_VALID   = out_valid;
    assign OUT_DATA    = main_data_reg;
    assign OUT_CTRL    = out_valid ? main_ctrl_reg : CTRL_BUBBLE;
    assign STALL_COUNT = stall_count_reg;

endmodule

// File: tb/tb_id_ex_elastic_stage.sv
// Bench for id_ex_elastic_stage: lane 0 built with the skid slot, lane 1 without; both share stimulus
// and are checked against a queue-based model of an elastic stage of depth 2 or 1.
module tb_id_ex_elastic_stage;

    localparam int unsigned DW = 32;
    localparam int unsigned CW = 8;
    localparam logic [CW-1:0] BUBBLE = 8'h5A;

    typedef struct packed {
        logic [DW-1:0] d;
        logic [CW-1:0] c;
    } entry_t;

    logic          clk;
    logic          rst;
    logic          busywait;
    logic          flush;
    logic          in_valid;
    logic [DW-1:0] in_data;
    logic [CW-1:0] in_ctrl;
    logic          out_ready;

    int  n_checks = 0;
    int  n_fail   = 0;
    bit  chk_en   = 0;
    int  seq      = 1;
    logic lane0_ready_s;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input int lane, input string name, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL lane%0d %s: got %0h expected %0h at %0t", lane, name, got, exp, $time);
        end
    endtask

    generate
        for (genvar gi = 0; gi < 2; gi++) begin : g_lane
            logic          in_ready;
            logic          out_valid;
            logic [DW-1:0] out_data;
            logic [CW-1:0] out_ctrl;
            logic [15:0]   stall_count;

            entry_t q[$];
            int     stall_model = 0;
            bit     loaded      = 0;
            bit     m_ready     = 0;
            bit     m_rel, m_inc, m_rst, m_fl;
            int     depth;

            id_ex_elastic_stage #(
                .DATA_W     (DW),
                .CTRL_W     (CW),
                .CTRL_BUBBLE(BUBBLE),
                .SKID_EN    (gi == 0)
            ) dut (
                .CLK        (clk),
                .RESET      (rst),
                .BUSYWAIT   (busywait),
                .FLUSH      (flush),
                .IN_VALID   (in_valid),
                .IN_READY   (in_ready),
                .IN_DATA    (in_data),
                .IN_CTRL    (in_ctrl),
                .OUT_VALID  (out_valid),
                .OUT_READY  (out_ready),
                .OUT_DATA   (out_data),
                .OUT_CTRL   (out_ctrl),
                .STALL_COUNT(stall_count)
            );

            // Issue side: an accepted entry is pushed as the expected future output.
            always @(posedge clk) begin
                if (!rst && !flush && in_valid && m_ready) begin
                    q.push_back('{d: in_data, c: in_ctrl});
                    loaded = 1;
                end
            end

            // Monitor: compare at negedge, then apply the clock edge to the model.
            always begin
                @(negedge clk);
                depth   = (gi == 0) ? 2 : 1;
                m_ready = !busywait && ((gi == 0) ? (q.size() < depth)
                                                  : (q.size() == 0 || out_ready));
                if (chk_en) begin
                    chk(gi, "out_valid", 64'(out_valid), 64'(q.size() > 0));
                    chk(gi, "in_ready", 64'(in_ready), 64'(m_ready));
                    chk(gi, "stall_count", 64'(stall_count), 64'(stall_model));
                    if (q.size() > 0) begin
                        chk(gi, "out_data", 64'(out_data), 64'(q[0].d));
                        chk(gi, "out_ctrl", 64'(out_ctrl), 64'(q[0].c));
                    end else begin
                        chk(gi, "bubble_ctrl", 64'(out_ctrl), 64'(BUBBLE));
                        if (!loaded) chk(gi, "reset_data", 64'(out_data), 64'd0);
                    end
                end
                m_rst = rst;
                m_fl  = flush;
                m_rel = (q.size() > 0) && out_ready && !busywait;
                m_inc = busywait || ((q.size() > 0) && !out_ready);
                @(posedge clk);
                if (m_rst) begin
                    q.delete();
                    stall_model = 0;
                    loaded      = 0;
                end else begin
                    if (m_inc && stall_model < 65535) stall_model++;
                    if (m_fl) q.delete();
                    else if (m_rel) void'(q.pop_front());
                end
            end
        end
    endgenerate

    // One cycle of stimulus; the sequence number advances only when the skid lane took the entry.
    task automatic step(input bit r, input bit iv, input bit bw, input bit fl, input bit ordy);
        bit adv;
        @(negedge clk);
        lane0_ready_s = g_lane[0].in_ready;
        adv = in_valid && lane0_ready_s && !flush && !rst;
        @(posedge clk);
        #1;
        if (adv) seq++;
        rst       = r;
        in_valid  = iv;
        busywait  = bw;
        flush     = fl;
        out_ready = ordy;
        in_data   = {seq[15:0], 16'($urandom)};
        in_ctrl   = 8'($urandom);
    endtask

    initial begin
        rst = 1; busywait = 0; flush = 0; in_valid = 0; out_ready = 1;
        in_data = '0; in_ctrl = '0;

        step(1, 0, 0, 0, 1);
        chk_en = 1;
        step(1, 0, 0, 0, 1);
        seq = 1;

        // Streaming
        repeat (8) step(0, 1, 0, 0, 1);
        repeat (2) step(0, 0, 0, 0, 1);
        // Backpressure for three cycles
        repeat (2) step(0, 1, 0, 0, 1);
        repeat (3) step(0, 1, 0, 0, 0);
        repeat (4) step(0, 1, 0, 0, 1);
        // BUSYWAIT pulse mid-stream
        repeat (2) step(0, 1, 0, 0, 1);
        repeat (4) step(0, 1, 1, 0, 1);
        repeat (3) step(0, 1, 0, 0, 1);
        // FLUSH while the skid lane is holding two entries
        repeat (3) step(0, 1, 0, 0, 0);
        step(0, 1, 0, 1, 0);
        repeat (3) step(0, 1, 0, 0, 1);
        // RESET while full with BUSYWAIT high
        repeat (3) step(0, 1, 0, 0, 0);
        step(1, 1, 1, 0, 0);
        repeat (2) step(0, 0, 0, 0, 1);

        // Randomized traffic
        for (int i = 0; i < 3000; i++) begin
            step($urandom_range(0, 199) == 0,
                 $urandom_range(0, 99) < 75,
                 $urandom_range(0, 99) < 10,
                 $urandom_range(0, 99) < 3,
                 $urandom_range(0, 99) < 70);
        end

        // Stall counter saturation
        step(1, 0, 0, 0, 1);
        repeat (65600) step(0, 1, 0, 0, 0);
        repeat (4) step(0, 0, 0, 0, 1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
